// File: rtl/reg_file_xcpt.sv
// 32x32 GPR file (r0 hardwired zero, write-first bypass) with user/supervisor
// exception state: saved PC/addr/type, redirect pulses, sticky double fault, saturating count.
package reg_file_xcpt_pkg;
   typedef enum logic [3:0] {
      XCPT_NONE       = 4'd0,
      XCPT_ILLEGAL    = 4'd1,
      XCPT_MISALIGN   = 4'd2,
      XCPT_PAGE_FAULT = 4'd3,
      XCPT_SYSCALL    = 4'd4
   } xcpt_type_t;
endpackage

module reg_file_xcpt
   import reg_file_xcpt_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  wr_dest,
   input  logic [31:0] wr_data,
   input  logic [4:0]  rd_a_addr,
   input  logic [4:0]  rd_b_addr,
   output logic [31:0] rd_a_data,
   output logic [31:0] rd_b_data,
   input  logic        xcpt_valid,
   input  xcpt_type_t  xcpt_type,
   input  logic [31:0] xcpt_pc,
   input  logic [31:0] xcpt_addr,
   input  logic        iret_req,
   input  logic [1:0]  rm_sel,
   output logic [31:0] rm_rd_data,
   output logic        priv_mode,
   output logic        xcpt_redirect,
   output logic        iret_redirect,
   output logic [31:0] redirect_pc,
   output logic        double_fault,
   output logic [15:0] xcpt_count
);

   localparam logic [31:0] HANDLER_BASE = 32'h0000_2000;

   typedef enum logic {
      USER  = 1'b0,
      SUPER = 1'b1
   } mode_t;

   mode_t       mode_q;
   mode_t       mode_d;
   logic        take_xcpt;
   logic        take_iret;
   logic        nested_xcpt;
   logic        commit;
   logic [31:0] gpr [32];
   logic [31:0] rm0;
   logic [31:0] rm1;
   xcpt_type_t  rm2;

   // A faulting instruction never commits its writeback.
   assign commit = wr_en && !xcpt_valid && (wr_dest != 5'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q <= SUPER;
      end else begin
         mode_q <= mode_d;
      end
   end

   // Exception beats iret; an exception while already in SUPER is a double fault.
   always_comb begin
      mode_d      = mode_q;
      take_xcpt   = 1'b0;
      take_iret   = 1'b0;
      nested_xcpt = 1'b0;
      case (mode_q)
         USER: begin
            if (xcpt_valid) begin
               mode_d    = SUPER;
               take_xcpt = 1'b1;
            end
         end
         SUPER: begin
            if (xcpt_valid) begin
               nested_xcpt = 1'b1;
            end else if (iret_req) begin
               mode_d    = USER;
               take_iret = 1'b1;
            end
         end
         default: mode_d = SUPER;
      endcase
   end

   assign priv_mode = (mode_q == SUPER);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rm0           <= '0;
         rm1           <= '0;
         rm2           <= XCPT_NONE;
         xcpt_redirect <= 1'b0;
         iret_redirect <= 1'b0;
         double_fault  <= 1'b0;
         xcpt_count    <= '0;
      end else begin
         xcpt_redirect <= take_xcpt;
         iret_redirect <= take_iret;
         if (take_xcpt) begin
            rm0 <= xcpt_pc;
            rm1 <= xcpt_addr;
            rm2 <= xcpt_type;
         end
         if (nested_xcpt) begin
            double_fault <= 1'b1;
         end
         if (xcpt_valid && (xcpt_count != 16'hFFFF)) begin
            xcpt_count <= xcpt_count + 16'd1;
         end
      end
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            gpr[i] <= '0;
         end
      end else if (commit) begin
         gpr[wr_dest] <= wr_data;
      end
   end

   always_comb begin
      rd_a_data = gpr[rd_a_addr];
      if (rd_a_addr == 5'd0) begin
         rd_a_data = '0;
      end else if (commit && (wr_dest == rd_a_addr)) begin
         rd_a_data = wr_data;
      end
   end

   always_comb begin
      rd_b_data = gpr[rd_b_addr];
      if (rd_b_addr == 5'd0) begin
         rd_b_data = '0;
      end else if (commit && (wr_dest == rd_b_addr)) begin
         rd_b_data = wr_data;
      end
   end

   always_comb begin
      rm_rd_data = '0;
      if (priv_mode) begin
         case (rm_sel)
            2'd0:    rm_rd_data = rm0;
            2'd1:    rm_rd_data = rm1;
            2'd2:    rm_rd_data = {28'd0, rm2};
            default: rm_rd_data = '0;
         endcase
      end
   end

   // The two pulses are exclusive by construction: one needs USER, the other SUPER.
   always_comb begin
      redirect_pc = '0;
      if (xcpt_redirect) begin
         redirect_pc = HANDLER_BASE;
      end else if (iret_redirect) begin
         redirect_pc = rm0;
      end
   end

endmodule

// File: tb/tb_reg_file_xcpt.sv
// Directed self-checking bench for reg_file_xcpt.
module tb_reg_file_xcpt;
   import reg_file_xcpt_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_dest;
   logic [31:0] wr_data;
   logic [4:0]  rd_a_addr;
   logic [4:0]  rd_b_addr;
   logic [31:0] rd_a_data;
   logic [31:0] rd_b_data;
   logic        xcpt_valid;
   xcpt_type_t  xcpt_type;
   logic [31:0] xcpt_pc;
   logic [31:0] xcpt_addr;
   logic        iret_req;
   logic [1:0]  rm_sel;
   logic [31:0] rm_rd_data;
   logic        priv_mode;
   logic        xcpt_redirect;
   logic        iret_redirect;
   logic [31:0] redirect_pc;
   logic        double_fault;
   logic [15:0] xcpt_count;

   int checks = 0;
   int failures = 0;

   reg_file_xcpt dut (
      .clock(clock), .reset(reset),
      .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
      .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
      .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
      .xcpt_valid(xcpt_valid), .xcpt_type(xcpt_type),
      .xcpt_pc(xcpt_pc), .xcpt_addr(xcpt_addr),
      .iret_req(iret_req), .rm_sel(rm_sel), .rm_rd_data(rm_rd_data),
      .priv_mode(priv_mode), .xcpt_redirect(xcpt_redirect),
      .iret_redirect(iret_redirect), .redirect_pc(redirect_pc),
      .double_fault(double_fault), .xcpt_count(xcpt_count)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; wr_en = 0; wr_dest = 0; wr_data = 0; rd_a_addr = 5'd7; rd_b_addr = 5'd8;
      xcpt_valid = 0; xcpt_type = XCPT_NONE; xcpt_pc = 0; xcpt_addr = 0; iret_req = 0; rm_sel = 0;
      #1;
      checks++; if (priv_mode !== 1'b1) begin failures++; $display("FAIL reset_priv: got %0h want 1", priv_mode); end
      checks++; if (double_fault !== 1'b0) begin failures++; $display("FAIL reset_df: got %0h want 0", double_fault); end
      checks++; if (xcpt_count !== 16'h0) begin failures++; $display("FAIL reset_count: got %0h want 0", xcpt_count); end
      checks++; if ({xcpt_redirect, iret_redirect} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {xcpt_redirect, iret_redirect}); end
      checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
      checks++; if (rd_a_data !== 32'h0 || rd_b_data !== 32'h0) begin failures++; $display("FAIL reset_gpr: got %h/%h want 0/0", rd_a_data, rd_b_data); end
      checks++; if (rm_rd_data !== 32'h0) begin failures++; $display("FAIL reset_rm0: got %h want 0", rm_rd_data); end
      tick; tick;
      reset = 1'b0;
      tick;
      checks++; if (priv_mode !== 1'b1 || xcpt_count !== 16'h0) begin failures++; $display("FAIL reset_release: got priv %0h cnt %0h want 1/0", priv_mode, xcpt_count); end
   endtask

   task automatic test_write_read;
      wr_en = 1; wr_dest = 5'd5; wr_data = 32'hDEADBEEF; rd_a_addr = 5'd5; rd_b_addr = 5'd5;
      #1;
      checks++; if (rd_a_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_a: got %h want deadbeef", rd_a_data); end
      checks++; if (rd_b_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_b: got %h want deadbeef", rd_b_data); end
      tick;
      wr_dest = 5'd6; wr_data = 32'h0BADF00D;
      tick;
      wr_en = 0; rd_b_addr = 5'd6;
      #1;
      checks++; if (rd_a_data !== 32'hDEADBEEF) begin failures++; $display("FAIL stored_r5: got %h want deadbeef", rd_a_data); end
      checks++; if (rd_b_data !== 32'h0BADF00D) begin failures++; $display("FAIL stored_r6: got %h want 0badf00d", rd_b_data); end
   endtask

   task automatic test_r0;
      wr_en = 1; wr_dest = 5'd0; wr_data = 32'h1234; rd_a_addr = 5'd0;
      #1;
      checks++; if (rd_a_data !== 32'h0) begin failures++; $display("FAIL r0_bypass: got %h want 0", rd_a_data); end
      tick;
      wr_en = 0;
      #1;
      checks++; if (rd_a_data !== 32'h0) begin failures++; $display("FAIL r0_stored: got %h want 0", rd_a_data); end
   endtask

   task automatic test_xcpt_from_user;
      wr_en = 1; wr_dest = 5'd3; wr_data = 32'h33333333;
      tick;
      wr_en = 0; iret_req = 1;
      tick;
      iret_req = 0;
      checks++; if (priv_mode !== 1'b0) begin failures++; $display("FAIL boot_iret_mode: got %0h want 0", priv_mode); end
      checks++; if (iret_redirect !== 1'b1 || redirect_pc !== 32'h0) begin failures++; $display("FAIL boot_iret_pulse: got %0h pc %h want 1 pc 0", iret_redirect, redirect_pc); end
      xcpt_valid = 1; xcpt_pc = 32'h1000; xcpt_addr = 32'h8000; xcpt_type = XCPT_PAGE_FAULT;
      wr_en = 1; wr_dest = 5'd3; wr_data = 32'hFFFFFFFF; rd_a_addr = 5'd3;
      #1;
      checks++; if (rd_a_data !== 32'h33333333) begin failures++; $display("FAIL xcpt_no_bypass: got %h want 33333333", rd_a_data); end
      tick;
      xcpt_valid = 0; wr_en = 0; rm_sel = 2'd0;
      #1;
      checks++; if (rd_a_data !== 32'h33333333) begin failures++; $display("FAIL xcpt_r3: got %h want 33333333", rd_a_data); end
      checks++; if (priv_mode !== 1'b1) begin failures++; $display("FAIL xcpt_mode: got %0h want 1", priv_mode); end
      checks++; if (xcpt_redirect !== 1'b1 || iret_redirect !== 1'b0) begin failures++; $display("FAIL xcpt_pulse: got %b want 10", {xcpt_redirect, iret_redirect}); end
      checks++; if (redirect_pc !== 32'h2000) begin failures++; $display("FAIL xcpt_rpc: got %h want 2000", redirect_pc); end
      checks++; if (rm_rd_data !== 32'h1000) begin failures++; $display("FAIL xcpt_rm0: got %h want 1000", rm_rd_data); end
      rm_sel = 2'd1; #1;
      checks++; if (rm_rd_data !== 32'h8000) begin failures++; $display("FAIL xcpt_rm1: got %h want 8000", rm_rd_data); end
      rm_sel = 2'd2; #1;
      checks++; if (rm_rd_data !== 32'h3) begin failures++; $display("FAIL xcpt_rm2: got %h want 3", rm_rd_data); end
      rm_sel = 2'd3; #1;
      checks++; if (rm_rd_data !== 32'h0) begin failures++; $display("FAIL xcpt_rm3: got %h want 0", rm_rd_data); end
      tick;
      checks++; if (xcpt_redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL xcpt_pulse_end: got %0h pc %h want 0 pc 0", xcpt_redirect, redirect_pc); end
      checks++; if (xcpt_count !== 16'd1) begin failures++; $display("FAIL xcpt_count1: got %0d want 1", xcpt_count); end
   endtask

   task automatic test_iret;
      iret_req = 1; rm_sel = 2'd0;
      tick;
      iret_req = 0;
      checks++; if (priv_mode !== 1'b0) begin failures++; $display("FAIL iret_mode: got %0h want 0", priv_mode); end
      checks++; if (iret_redirect !== 1'b1 || xcpt_redirect !== 1'b0) begin failures++; $display("FAIL iret_pulse: got %b want 01", {xcpt_redirect, iret_redirect}); end
      checks++; if (redirect_pc !== 32'h1000) begin failures++; $display("FAIL iret_rpc: got %h want 1000", redirect_pc); end
      checks++; if (rm_rd_data !== 32'h0) begin failures++; $display("FAIL iret_rm_hidden: got %h want 0", rm_rd_data); end
      tick;
      checks++; if (iret_redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL iret_pulse_end: got %0h pc %h want 0 pc 0", iret_redirect, redirect_pc); end
   endtask

   task automatic test_iret_in_user;
      iret_req = 1;
      tick;
      iret_req = 0;
      checks++; if (priv_mode !== 1'b0) begin failures++; $display("FAIL user_iret_mode: got %0h want 0", priv_mode); end
      checks++; if (iret_redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL user_iret_pulse: got %0h pc %h want 0 pc 0", iret_redirect, redirect_pc); end
   endtask

   task automatic test_double_fault;
      reset = 1; #1; reset = 0;
      iret_req = 1;
      tick;
      iret_req = 0;
      xcpt_valid = 1; xcpt_pc = 32'h1000; xcpt_addr = 32'h8800; xcpt_type = XCPT_MISALIGN;
      tick;
      checks++; if (xcpt_redirect !== 1'b1 || double_fault !== 1'b0) begin failures++; $display("FAIL df_first: got pulse %0h df %0h want 1/0", xcpt_redirect, double_fault); end
      xcpt_pc = 32'h1004; xcpt_addr = 32'h9000; xcpt_type = XCPT_ILLEGAL;
      tick;
      xcpt_valid = 0; rm_sel = 2'd0;
      #1;
      checks++; if (double_fault !== 1'b1) begin failures++; $display("FAIL df_set: got %0h want 1", double_fault); end
      checks++; if (xcpt_redirect !== 1'b0 || priv_mode !== 1'b1) begin failures++; $display("FAIL df_second: got pulse %0h priv %0h want 0/1", xcpt_redirect, priv_mode); end
      checks++; if (xcpt_count !== 16'd2) begin failures++; $display("FAIL df_count: got %0d want 2", xcpt_count); end
      checks++; if (rm_rd_data !== 32'h1000) begin failures++; $display("FAIL df_rm0: got %h want 1000", rm_rd_data); end
      rm_sel = 2'd1; #1;
      checks++; if (rm_rd_data !== 32'h8800) begin failures++; $display("FAIL df_rm1: got %h want 8800", rm_rd_data); end
      rm_sel = 2'd2; #1;
      checks++; if (rm_rd_data !== 32'h2) begin failures++; $display("FAIL df_rm2: got %h want 2", rm_rd_data); end
      iret_req = 1;
      tick;
      iret_req = 0;
      checks++; if (double_fault !== 1'b1 || priv_mode !== 1'b0) begin failures++; $display("FAIL df_sticky: got df %0h priv %0h want 1/0", double_fault, priv_mode); end
      checks++; if (redirect_pc !== 32'h1000) begin failures++; $display("FAIL df_iret_rpc: got %h want 1000", redirect_pc); end
   endtask

   task automatic test_xcpt_iret_same_cycle;
      xcpt_valid = 1; iret_req = 1; xcpt_pc = 32'h2222_0000; xcpt_addr = 32'h44; xcpt_type = XCPT_SYSCALL;
      tick;
      xcpt_valid = 0; iret_req = 0; rm_sel = 2'd0;
      #1;
      checks++; if (priv_mode !== 1'b1) begin failures++; $display("FAIL both_user_mode: got %0h want 1", priv_mode); end
      checks++; if ({xcpt_redirect, iret_redirect} !== 2'b10 || redirect_pc !== 32'h2000) begin failures++; $display("FAIL both_user_pulse: got %b pc %h want 10 pc 2000", {xcpt_redirect, iret_redirect}, redirect_pc); end
      checks++; if (rm_rd_data !== 32'h2222_0000) begin failures++; $display("FAIL both_user_rm0: got %h want 22220000", rm_rd_data); end
      xcpt_valid = 1; iret_req = 1; xcpt_pc = 32'h5555_0000;
      tick;
      xcpt_valid = 0; iret_req = 0;
      #1;
      checks++; if (priv_mode !== 1'b1 || {xcpt_redirect, iret_redirect} !== 2'b00) begin failures++; $display("FAIL both_super: got priv %0h pulses %b want 1/00", priv_mode, {xcpt_redirect, iret_redirect}); end
      checks++; if (rm_rd_data !== 32'h2222_0000) begin failures++; $display("FAIL both_super_rm0: got %h want 22220000", rm_rd_data); end
      checks++; if (xcpt_count !== 16'd4) begin failures++; $display("FAIL both_count: got %0d want 4", xcpt_count); end
   endtask

   task automatic test_saturation;
      reset = 1; #1; reset = 0;
      xcpt_valid = 1; xcpt_pc = 32'h3000;
      repeat (65537) tick;
      xcpt_valid = 0;
      #1;
      checks++; if (xcpt_count !== 16'hFFFF) begin failures++; $display("FAIL sat_count: got %h want ffff", xcpt_count); end
      checks++; if (double_fault !== 1'b1 || priv_mode !== 1'b1) begin failures++; $display("FAIL sat_state: got df %0h priv %0h want 1/1", double_fault, priv_mode); end
   endtask

   task automatic test_reset_mid_pulse;
      wr_en = 1; wr_dest = 5'd9; wr_data = 32'h99;
      tick;
      wr_en = 0; iret_req = 1; rd_a_addr = 5'd9; rm_sel = 2'd0;
      tick;
      iret_req = 0;
      checks++; if (iret_redirect !== 1'b1 || rd_a_data !== 32'h99) begin failures++; $display("FAIL pre_reset: got pulse %0h r9 %h want 1/99", iret_redirect, rd_a_data); end
      reset = 1;
      #1;
      checks++; if (iret_redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL mid_reset_pulse: got %0h pc %h want 0 pc 0", iret_redirect, redirect_pc); end
      checks++; if (priv_mode !== 1'b1 || double_fault !== 1'b0 || xcpt_count !== 16'h0) begin failures++; $display("FAIL mid_reset_state: got priv %0h df %0h cnt %h want 1/0/0", priv_mode, double_fault, xcpt_count); end
      checks++; if (rd_a_data !== 32'h0 || rm_rd_data !== 32'h0) begin failures++; $display("FAIL mid_reset_regs: got r9 %h rm0 %h want 0/0", rd_a_data, rm_rd_data); end
      #1;
      reset = 0;
      tick;
      checks++; if (iret_redirect !== 1'b0 || xcpt_redirect !== 1'b0 || priv_mode !== 1'b1 || xcpt_count !== 16'h0) begin failures++; $display("FAIL post_reset: got pulses %b priv %0h cnt %h want 00/1/0", {xcpt_redirect, iret_redirect}, priv_mode, xcpt_count); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_r0;
      test_xcpt_from_user;
      test_iret;
      test_iret_in_user;
      test_double_fault;
      test_xcpt_iret_same_cycle;
      test_saturation;
      test_reset_mid_pulse;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_xcpt.md
REG_FILE_XCPT -- requirements
Module: reg_file_xcpt

Interface
REQ-001 SHALL have port clock, input, 1 bit: single core clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports wr_en (input, 1), wr_dest (input, 5) and wr_data (input, 32): GPR write request from writeback.
REQ-004 SHALL have ports rd_a_addr and rd_b_addr (input, 5 each) and rd_a_data and rd_b_data (output, 32 each): decode read ports.
REQ-005 SHALL have ports xcpt_valid (input, 1), xcpt_type (input, xcpt_type_t), xcpt_pc (input, 32) and xcpt_addr (input, 32): exception report from writeback.
REQ-006 SHALL have port iret_req, input, 1 bit: return-from-exception request from decode.
REQ-007 SHALL have ports rm_sel (input, 2) and rm_rd_data (output, 32): special-register read, where 0 = rm0 (PC), 1 = rm1 (addr), 2 = rm2 (type, zero-extended) and 3 = 0.
REQ-008 SHALL have ports priv_mode (output, 1; 1 = supervisor), xcpt_redirect (output, 1), iret_redirect (output, 1) and redirect_pc (output, 32).
REQ-009 SHALL have ports double_fault (output, 1, sticky) and xcpt_count (output, 16).

Function
REQ-010 SHALL hold 32 GPRs x 32 bits; r0 SHALL read as 0 and writes to r0 SHALL be discarded.
REQ-011 SHALL perform GPR writes on the clock edge when wr_en=1 and xcpt_valid=0.
- A write with xcpt_valid=1 in the same cycle SHALL be dropped; the faulting instruction does not commit.
REQ-012 Reads SHALL be combinational with write-first bypass.
- A rd_x_addr equal to a committing wr_dest (nonzero) SHALL return wr_data in the same cycle.
REQ-013 Mode FSM SHALL have two states, USER and SUPER. SUPER -> USER on iret_req. USER -> SUPER on xcpt_valid. There SHALL be no other transitions.
REQ-014 xcpt_valid in USER SHALL, on the edge, latch rm0=xcpt_pc, rm1=xcpt_addr and rm2=xcpt_type, and enter SUPER.
REQ-015 The cycle after REQ-014, xcpt_redirect SHALL pulse 1 for exactly 1 cycle with redirect_pc = 32'h0000_2000, the exception handler base.
REQ-016 xcpt_valid in SUPER SHALL leave rm0-rm2 unchanged and SHALL set double_fault=1, which stays set until reset; mode SHALL remain SUPER.
REQ-017 iret_req in SUPER with xcpt_valid=0 SHALL enter USER.
- The next cycle, iret_redirect SHALL pulse 1 for exactly 1 cycle with redirect_pc = rm0.
REQ-018 iret_req in USER SHALL be ignored: no state change and no pulse.
REQ-019 If xcpt_valid and iret_req occur in the same cycle, the exception SHALL take priority and iret_req SHALL be ignored.
REQ-020 xcpt_redirect and iret_redirect SHALL never be 1 simultaneously; redirect_pc SHALL be 0 when neither is asserted.
REQ-021 rm_rd_data SHALL be combinational and SHALL return 0 whenever priv_mode=0.
REQ-022 xcpt_count SHALL increment by 1 on every accepted xcpt_valid, including double faults, and SHALL saturate at 16'hFFFF without wrapping.
REQ-023 Back-to-back xcpt_valid on consecutive cycles SHALL behave as follows: the first is taken per REQ-014, and the second is a double fault per REQ-016.

Reset
REQ-024 On reset assertion all outputs and state SHALL clear asynchronously:
- GPRs = 0 and rm0-rm2 = 0.
- priv_mode = 1 (SUPER, boot mode).
- double_fault = 0, xcpt_count = 0.
- Both redirect pulses = 0, redirect_pc = 0.
REQ-025 Reset asserted mid-operation, including during a pending redirect pulse, SHALL cancel the pulse; the first edge after deassertion SHALL see reset state.

Verification
REQ-026 Write then read: wr_en=1, dest=5, data=0xDEADBEEF with rd_a_addr=5 in the same cycle -> rd_a_data=0xDEADBEEF that cycle and after the edge.
REQ-027 r0 check: write dest=0, data=0x1234 -> rd_a_data=0 for rd_a_addr=0.
REQ-028 Exception from USER:
- Stimulus: iret first to reach USER, then xcpt_valid with pc=0x1000, addr=0x8000 and a concurrent wr_en to r3.
- Response: r3 unchanged, xcpt_redirect pulses with redirect_pc=0x2000, priv_mode=1.
- rm_sel=0 -> 0x1000 and rm_sel=1 -> 0x8000.
REQ-029 iret: after REQ-028, assert iret_req -> priv_mode=0, and the next cycle iret_redirect=1 with redirect_pc=0x1000; rm_rd_data=0 thereafter.
REQ-030 Double fault: two consecutive xcpt_valid with pc 0x1000 then 0x1004 -> rm0=0x1000, double_fault=1, xcpt_count=2.
REQ-031 Saturation and reset:
- Force 65537 exceptions -> xcpt_count=0xFFFF.
- Assert reset mid-pulse -> all outputs return to reset values immediately.
